// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter
// Owns the SPI flash pins and shares them between an instruction-fetch port
// (16-bit words) and a constant-data port (bytes). Each request becomes one
// mode-0 READ (0x03) transaction: 8-bit command, 24-bit address, then 16 or
// 8 read bits. Simultaneous requests are served round-robin.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   if_req/if_addr      fetch request (level) and word address
//   if_rdata/if_ready   fetched word (first byte in [15:8]), 1-cycle pulse
//   d_req/d_addr        data request (level) and byte address
//   d_rdata/d_ready     fetched byte, 1-cycle pulse
//   busy                high whenever the FSM is not idle
//   spi_cs/sclk/mosi    flash outputs (cs active low, sclk idle low)
//   spi_miso            flash serial input
module spi_flash_arbiter #(
  parameter int          CLK_DIV   = 1,
  parameter logic [23:0] DATA_BASE = 24'h010000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic [7:0]  d_addr,
  output logic [7:0]  d_rdata,
  output logic        d_ready,
  output logic        busy,
  output logic        spi_cs,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

  localparam logic [3:0] DIV_M1 = 4'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic        gnt_data_q;   // port owning the current transaction
  logic        last_data_q;  // port of the most recent grant
  logic [5:0]  bit_q;        // index of the bit currently on the wire
  logic [3:0]  div_q;        // clk count within the current SCLK phase
  logic        hi_q;         // current SCLK phase (0 low, 1 high)
  logic [31:0] tx_q;         // command + address, MSB on the wire
  logic [15:0] rx_q;
  logic [15:0] if_rdata_q;
  logic [7:0]  d_rdata_q;
  logic        if_ready_q, d_ready_q;

  logic pick_data, div_end, bit_end, last_bit;

  always_comb begin
    // Fetch wins unless only data requests, or data did not get the last grant.
    pick_data = d_req & (~if_req | ~last_data_q);
    div_end   = (div_q == DIV_M1);
    bit_end   = div_end & hi_q;
    last_bit  = (bit_q == (gnt_data_q ? 6'd39 : 6'd47));
    state_d   = state_q;
    case (state_q)
      IDLE:    if (if_req | d_req) state_d = XFER;
      XFER:    if (bit_end & last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_data_q  <= 1'b0;
      last_data_q <= 1'b1;
      bit_q       <= '0;
      div_q       <= '0;
      hi_q        <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      case (state_q)
        IDLE: if (if_req | d_req) begin
          gnt_data_q  <= pick_data;
          last_data_q <= pick_data;
          // Data addresses wrap modulo 2^24 (self-determined 24-bit add).
          tx_q  <= {8'h03, pick_data ? DATA_BASE + {16'h0, d_addr}
                                     : {7'h0, if_addr, 1'b0}};
          bit_q <= '0;
          div_q <= '0;
          hi_q  <= 1'b0;
        end
        XFER: begin
          div_q <= div_end ? 4'd0 : div_q + 4'd1;
          if (div_end) begin
            hi_q <= ~hi_q;
            if (hi_q) begin
              // End of high phase: sample MISO, advance to the next bit.
              // Zeros shifted into tx keep MOSI low through the read bits.
              bit_q <= bit_q + 6'd1;
              tx_q  <= {tx_q[30:0], 1'b0};
              if (bit_q >= 6'd32) rx_q <= {rx_q[14:0], spi_miso};
            end
          end
        end
        DONE: begin
          if (gnt_data_q) begin
            d_rdata_q <= rx_q[7:0];
            d_ready_q <= 1'b1;
          end else begin
            if_rdata_q <= rx_q;
            if_ready_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign spi_cs   = (state_q != XFER);
  assign spi_sclk = (state_q == XFER) & hi_q;
  assign spi_mosi = (state_q == XFER) & tx_q[31];
  assign busy     = (state_q != IDLE);
  assign if_rdata = if_rdata_q;
  assign if_ready = if_ready_q;
  assign d_rdata  = d_rdata_q;
  assign d_ready  = d_ready_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Bench for spi_flash_arbiter: two instances (CLK_DIV 1 and 3), each with a
// behavioural flash, a round-robin reference model feeding an expectation
// queue, and a monitor popping the queue on every ready pulse.
module tb_spi_flash_arbiter;

  typedef struct {
    bit          dport;   // 1 = data port
    logic [23:0] addr;
    int          gcyc;    // cycle count at the grant edge
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]       rst = 2'b11, if_req = '0, d_req = '0;
  logic [1:0][15:0] if_addr = '0;
  logic [1:0][7:0]  d_addr = '0;
  logic [1:0][15:0] if_rdata;
  logic [1:0][7:0]  d_rdata;
  logic [1:0]       if_ready, d_ready, busy, cs, sclk, mosi;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Flash contents: a few fixed bytes for the directed cases, hash elsewhere.
  function automatic logic [7:0] mem(input logic [23:0] a);
    case (a)
      24'h000024: mem = 8'hA5;
      24'h000025: mem = 8'h3C;
      24'h0100FF: mem = 8'h81;
      default:    mem = a[7:0] ^ {a[12:8], a[23:21]} ^ 8'h96;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int DIV = (g == 0) ? 1 : 3;
    logic mi;
    txn_t q[$];

    spi_flash_arbiter #(.CLK_DIV(DIV), .DATA_BASE(24'h010000)) dut (
      .clk(clk), .rst(rst[g]),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]), .if_ready(if_ready[g]),
      .d_req(d_req[g]), .d_addr(d_addr[g]), .d_rdata(d_rdata[g]), .d_ready(d_ready[g]),
      .busy(busy[g]), .spi_cs(cs[g]), .spi_sclk(sclk[g]), .spi_mosi(mosi[g]), .spi_miso(mi)
    );

    // Inputs as the DUT sees them at each edge.
    logic s_rst, s_if, s_d;
    logic [15:0] s_ia;
    logic [7:0]  s_da;
    always @(posedge clk) begin
      s_rst <= rst[g]; s_if <= if_req[g]; s_d <= d_req[g];
      s_ia  <= if_addr[g]; s_da <= d_addr[g];
    end

    // Flash: captures command/address on SCLK rise, presents read bits from
    // the rise onward and scrambles MISO during every low phase.
    initial begin
      int nb, lr, j, idx;
      logic [31:0] hdr;
      logic [23:0] fa;
      logic [7:0]  b;
      logic ps, pc;
      nb = 0; lr = 0; hdr = '0; fa = '0; ps = 1'b0; pc = 1'b1; mi = 1'b0;
      forever begin
        @(sclk[g] or cs[g]);
        if (!cs[g] && pc) nb = 0;
        if (sclk[g] && !ps) begin
          if (nb > 0) chk($sformatf("sclk_period%0d", g), cyc - lr, 2 * DIV);
          lr = cyc;
          if (nb < 32) begin
            hdr = {hdr[30:0], mosi[g]};
            nb++;
            if (nb == 32) begin
              fa = hdr[23:0];
              chk($sformatf("mosi_cmd%0d", g), hdr[31:24], 8'h03);
              if (q.size() == 0) chk($sformatf("addr_no_txn%0d", g), 1, 0);
              else chk($sformatf("mosi_addr%0d", g), fa, q[$].addr);
            end
          end else begin
            chk($sformatf("mosi_read_zero%0d", g), mosi[g], 0);
            j = nb - 32;
            b = mem(fa + 24'(j / 8));
            idx = 7 - (j % 8);
            mi = b[idx];
            nb++;
          end
        end else if (!sclk[g] && ps) begin
          mi = 1'($urandom);
        end
        ps = sclk[g];
        pc = cs[g];
      end
    end

    // Reference model + monitor.
    initial begin
      bit pcs, idle_prev, last_data, pd;
      int lo, hi, bits;
      logic [15:0] exp_ird;
      logic [7:0]  exp_drd;
      txn_t t;
      pcs = 1; idle_prev = 1; last_data = 1; lo = 0; hi = 99; exp_ird = '0; exp_drd = '0;
      forever begin
        @(negedge clk);
        if (s_rst) begin
          q.delete(); last_data = 1; pcs = 1; idle_prev = 1; hi = 99; lo = 0;
          exp_ird = '0; exp_drd = '0;
        end else begin
          if (pcs && !cs[g]) begin
            chk($sformatf("cs_gap%0d", g), hi >= 2, 1);
            if (!s_if && !s_d) chk($sformatf("spurious_grant%0d", g), 1, 0);
            pd = s_d && (!s_if || !last_data);
            last_data = pd;
            t.dport = pd;
            t.addr  = pd ? 24'h010000 + {16'h0, s_da} : {7'h0, s_ia, 1'b0};
            t.gcyc  = cyc;
            q.push_back(t);
            lo = 0;
          end else if (idle_prev && cs[g] && (s_if || s_d)) begin
            chk($sformatf("missed_grant%0d", g), 1, 0);
          end
          if (!pcs && cs[g] && q.size() > 0)
            chk($sformatf("cs_low_len%0d", g), lo, (q[0].dport ? 40 : 48) * 2 * DIV);
          if (cs[g]) begin
            if (!pcs) hi = 0;
            hi++;
          end else lo++;
          if (if_ready[g] && d_ready[g]) chk($sformatf("both_ready%0d", g), 1, 0);
          if (if_ready[g] || d_ready[g]) begin
            if (q.size() == 0) chk($sformatf("unexpected_ready%0d", g), 1, 0);
            else begin
              t = q.pop_front();
              bits = t.dport ? 40 : 48;
              chk($sformatf("ready_port%0d", g), d_ready[g], t.dport);
              chk($sformatf("latency%0d", g), cyc - t.gcyc, bits * 2 * DIV + 1);
              if (t.dport) begin
                exp_drd = mem(t.addr);
                chk($sformatf("d_rdata%0d", g), d_rdata[g], exp_drd);
                chk($sformatf("if_rdata_hold%0d", g), if_rdata[g], exp_ird);
              end else begin
                exp_ird = {mem(t.addr), mem(t.addr + 24'd1)};
                chk($sformatf("if_rdata%0d", g), if_rdata[g], exp_ird);
                chk($sformatf("d_rdata_hold%0d", g), d_rdata[g], exp_drd);
              end
            end
          end
          idle_prev = cs[g] && (q.size() == 0);
          pcs = cs[g];
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rdy(input int i, input bit dp, input int budget, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(dp ? d_ready[i] : if_ready[i]) && n < budget);
    chk(nm, dp ? d_ready[i] : if_ready[i], 1);
  endtask

  task automatic wait_cs_low(input int i, input int budget, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (cs[i] && n < budget);
    chk(nm, cs[i], 0);
  endtask

  task automatic wait_any(input int budget, output int port);
    int n = 0;
    port = -1;
    do begin @(negedge clk); n++; end
    while (!if_ready[0] && !d_ready[0] && n < budget);
    if (if_ready[0]) port = 0;
    else if (d_ready[0]) port = 1;
  endtask

  initial begin
    int p, done[2], cd[2], wt[2];
    bit rdy, rq;

    // Reset values on both instances.
    tick(3);
    for (int i = 0; i < 2; i++) begin
      chk("rst_cs", cs[i], 1);          chk("rst_sclk", sclk[i], 0);
      chk("rst_mosi", mosi[i], 0);      chk("rst_busy", busy[i], 0);
      chk("rst_if_ready", if_ready[i], 0); chk("rst_d_ready", d_ready[i], 0);
      chk("rst_if_rdata", if_rdata[i], 0); chk("rst_d_rdata", d_rdata[i], 0);
    end
    rst = 2'b00;
    tick(2);

    // CLK_DIV=3 fetch (latency and period checked by the monitor/flash).
    if_addr[1] = 16'h0012; if_req[1] = 1'b1;
    wait_rdy(1, 0, 400, "div3_if_ready");
    if_req[1] = 1'b0;
    chk("div3_if_rdata", if_rdata[1], 16'hA53C);
    tick(3);

    // Fetch only.
    if_addr[0] = 16'h0012; if_req[0] = 1'b1;
    wait_rdy(0, 0, 150, "fetch_ready");
    if_req[0] = 1'b0;
    chk("fetch_rdata", if_rdata[0], 16'hA53C);
    tick(3);

    // Data only, top of the data window.
    d_addr[0] = 8'hFF; d_req[0] = 1'b1;
    wait_rdy(0, 1, 150, "data_ready");
    d_req[0] = 1'b0;
    chk("data_rdata", d_rdata[0], 8'h81);
    tick(3);

    // Both requesting from reset: strict alternation starting with fetch.
    rst[0] = 1'b1;
    if_addr[0] = 16'h0100; d_addr[0] = 8'h10; if_req[0] = 1'b1; d_req[0] = 1'b1;
    tick(2);
    rst[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_any(250, p);
      chk($sformatf("rr_order%0d", k), p, k % 2);
    end
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    tick(3);

    // Fetch dropped at cycle 10 of its transfer, data waiting behind it.
    if_addr[0] = 16'h0333; if_req[0] = 1'b1;
    wait_cs_low(0, 10, "drop_grant");
    tick(1);
    d_addr[0] = 8'h42; d_req[0] = 1'b1;
    tick(8);
    if_req[0] = 1'b0;
    wait_rdy(0, 0, 150, "drop_if_ready");
    wait_rdy(0, 1, 150, "drop_then_data");
    d_req[0] = 1'b0;
    tick(3);

    // Reset at cycle 40 of a fetch.
    if_addr[0] = 16'h0777; if_req[0] = 1'b1;
    wait_cs_low(0, 10, "rst_mid_grant");
    tick(39);
    rst[0] = 1'b1; if_req[0] = 1'b0;
    tick(1);
    chk("midrst_cs", cs[0], 1);          chk("midrst_sclk", sclk[0], 0);
    chk("midrst_if_rdata", if_rdata[0], 0); chk("midrst_if_ready", if_ready[0], 0);
    chk("midrst_busy", busy[0], 0);
    rst[0] = 1'b0;
    tick(1);
    if_addr[0] = 16'h1234; if_req[0] = 1'b1;
    wait_rdy(0, 0, 150, "post_rst_fetch");
    if_req[0] = 1'b0;
    tick(3);

    // Randomized traffic on both ports.
    done = '{0, 0}; cd = '{0, 0}; wt = '{0, 0};
    for (int c = 0; c < 20000 && (done[0] < 15 || done[1] < 15); c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        rdy = k ? d_ready[0] : if_ready[0];
        rq  = k ? d_req[0] : if_req[0];
        if (rq) begin
          if (rdy) begin
            done[k]++; wt[k] = 0;
            if ($urandom_range(1, 0) == 1) begin
              if (k) d_addr[0] = 8'($urandom); else if_addr[0] = 16'($urandom);
            end else begin
              if (k) d_req[0] = 1'b0; else if_req[0] = 1'b0;
              cd[k] = $urandom_range(15, 0);
            end
          end else if (++wt[k] > 200) begin
            chk($sformatf("starved%0d", k), wt[k], 0);
            wt[k] = 0;
          end
        end else if (cd[k] == 0) begin
          if (k) begin d_addr[0] = 8'($urandom); d_req[0] = 1'b1; end
          else begin if_addr[0] = 16'($urandom); if_req[0] = 1'b1; end
        end else cd[k]--;
      end
    end
    chk("rand_fetch_done", done[0] >= 15, 1);
    chk("rand_data_done", done[1] >= 15, 1);
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    tick(250);
    chk("end_idle", busy[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
